// File: rtl/uart_boot_loader.sv
// UART boot loader: assembles a length-prefixed little-endian byte stream into
// 32-bit instruction-memory writes and releases the core once the image is in.
module uart_boot_loader #(
    parameter int          FREQ      = 100000000,
    parameter int          BAUDRATE  = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          TIMEOUT   = (FREQ / BAUDRATE) * 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LEN_HI, DATA, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [15:0]   word_idx_q, word_idx_d;
    logic [23:0]   word_q, word_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          last_q, last_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [15:0]   cnt_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            byte_idx_q  <= '0;
            word_idx_q  <= '0;
            word_q      <= '0;
            tmo_q       <= '0;
            last_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            word_q      <= word_d;
            tmo_q       <= tmo_d;
            last_q      <= last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        word_d      = word_q;
        tmo_d       = tmo_q;
        last_d      = last_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cnt_full    = {rx_data, count_q[7:0]};

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (rx_valid) begin
                    count_d    = {8'h00, rx_data};
                    err_d      = 1'b0;
                    cpu_hold_d = 1'b1;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    tmo_d   = '0;
                    count_d = cnt_full;
                    if (cnt_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({16'd0, cnt_full} > 32'(MAX_WORDS)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = '0;
                        word_idx_d = '0;
                        last_d     = 1'b0;
                        state_d    = DATA;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DATA: begin
                // After the final write we spend one cycle here so that done
                // lands in the cycle following the last mem_we.
                if (last_q) begin
                    state_d = DONE;
                end else if (rx_valid) begin
                    tmo_d      = '0;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = {rx_data, word_q};
                            mem_addr_d  = BASE_ADDR + 32'({word_idx_q, 2'b00});
                            word_idx_d  = word_idx_q + 16'd1;
                            if (word_idx_q == count_q - 16'd1)
                                last_d = 1'b1;
                        end
                    endcase
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                tmo_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
        end
        busy_d = (state_d == LEN_HI) || (state_d == DATA);
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule
